ahb_mtx_qos_arbiter: RTL and testbench
======================================

AHB_MTX_QOS_ARBITER -- requirements
Module: ahb_mtx_qos_arbiter

Interface
REQ-001 Parameter AGE_LIMIT, default 8, range 1..15: wait-cycle count at which a pending port is promoted to urgent.
REQ-002 HCLK  input  1  AHB system clock; all state on rising edge.
REQ-003 HRESET  input  1  asynchronous, active-high reset.
REQ-004 req_port  input  4  per-input-port request; bit i = port i.
REQ-005 prio_cfg  input  8  static priority, bits [2i+1:2i] = port i; 3 is highest.
REQ-006 HREADYM  input  1  transfer done on the output (slave) side.
REQ-007 HSELM  input  1  slave select of the currently routed transfer.
REQ-008 HTRANSM  input  2  transfer type (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11).
REQ-009 HBURSTM  input  3  burst type, standard AHB encoding.
REQ-010 HMASTLOCKM  input  1  locked transfer.
REQ-011 addr_in_port  output  2  index of the granted port.
REQ-012 no_port  output  1  no port granted.
REQ-013 starve_flag  output  4  bit i set while port i is urgent.

Function
REQ-014 All registers SHALL update only on HCLK edges with HREADYM=1; with HREADYM=0 all state SHALL hold.
REQ-015 Burst remain counter (4 bits): HSELM=0 or IDLE -> 0; NONSEQ loads 15/7/3 for x16/x8/x4 bursts, 3 for INCR, 0 for SINGLE; SEQ decrements, saturating at 0; BUSY holds.
REQ-016 next_hold SHALL be 1 when the next counter value is nonzero.
REQ-017 When HMASTLOCKM=1 or next_hold=1, addr_in_port and no_port SHALL hold.
REQ-018 Otherwise, effective priority of port i = 4 if age[i] >= AGE_LIMIT, else prio_cfg[i]; the requesting port with the highest effective priority SHALL be granted.
REQ-019 Ties SHALL be broken round-robin, starting at (addr_in_port+1) mod 4 and wrapping 3 -> 0; when no_port=1, search starts at port 0.
REQ-020 With no requests: if no_port=0 and HSELM=1, the current grant SHALL hold; otherwise no_port SHALL go to 1 and addr_in_port SHALL hold.
REQ-021 Age counter per port (4 bits), cleared on the update in which the port is granted or its req_port bit is 0.
REQ-022 The age counter SHALL increment, saturating at 15, while the port is requesting and not granted.
REQ-023 starve_flag[i] SHALL be the registered value of (age[i] >= AGE_LIMIT).
REQ-024 Grant latency SHALL be one HREADYM-qualified cycle from request to addr_in_port change.
REQ-025 Simultaneous urgent ports SHALL resolve by REQ-019 round-robin order.
REQ-026 The granted port SHALL not age even if its req_port bit stays set.

Reset
REQ-027 On HRESET=1: no_port=1, addr_in_port=0, starve_flag=0, all age counters=0, burst counter=0 and hold=0, immediately and independent of HCLK.
REQ-028 Reset asserted mid-burst or mid-lock SHALL abandon the hold; the first post-reset decision follows REQ-019 from port 0.

Structure
REQ-029 HTRANS/HBURST encodings and the AGE_LIMIT default SHALL live in shared package ahb_mtx_pkg.
REQ-030 Burst counter and hold logic (REQ-015/016) SHALL be sub-module ahb_mtx_burst_tracker; arbitration and aging stay in the top module.

Verification
REQ-031 Reset -> no_port=1, addr_in_port=0, starve_flag=0; then req_port=0100, HREADYM=1 -> next cycle addr_in_port=2, no_port=0.
REQ-032 prio_cfg=all 2, req_port=1111 held, one SINGLE per grant -> grants 1,2,3,0,... starting from port 0 grant.
REQ-033 Port 0 in INCR8 (NONSEQ + 7 SEQ, 2 BUSY inserted), port 1 requesting at higher priority -> grant stays 0 until the last SEQ accepted, then moves to 1.
REQ-034 AGE_LIMIT=8, prio_cfg port3=0, others=3, req_port=1111 -> starve_flag[3]=1 after 8 ungranted update cycles; port 3 granted at the next decision; age cleared.
REQ-035 HMASTLOCKM=1 with competing requests over 20 cycles -> no grant change; HREADYM=0 for 5 cycles -> ages and grant frozen.
REQ-036 HRESET pulsed mid-INCR16 at beat 5 -> outputs at reset values asynchronously; the next request is granted without burst hold.

Source files
------------

// File: rtl/ahb_mtx_pkg.sv
// Shared AHB encodings and defaults for the matrix QoS arbiter.
// Burst lengths are expressed as remaining beats after NONSEQ.
package ahb_mtx_pkg;

    localparam int AGE_LIMIT_DEF = 8;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'b000,
        HB_INCR   = 3'b001,
        HB_WRAP4  = 3'b010,
        HB_INCR4  = 3'b011,
        HB_WRAP8  = 3'b100,
        HB_INCR8  = 3'b101,
        HB_WRAP16 = 3'b110,
        HB_INCR16 = 3'b111
    } hburst_e;

    // Undefined-length INCR is held like a 4-beat burst.
    function automatic logic [3:0] burst_remain(input hburst_e b);
        logic [3:0] r;
        r = 4'd0;
        unique case (b)
            HB_SINGLE:           r = 4'd0;
            HB_INCR:             r = 4'd3;
            HB_WRAP4, HB_INCR4:  r = 4'd3;
            HB_WRAP8, HB_INCR8:  r = 4'd7;
            HB_WRAP16, HB_INCR16: r = 4'd15;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ahb_mtx_burst_tracker.sv
// Tracks remaining beats of the routed burst so the grant
// is not moved in the middle of a fixed-length transfer.
module ahb_mtx_burst_tracker
    import ahb_mtx_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       HREADYM,
    input  logic       HSELM,
    input  logic [1:0] HTRANSM,
    input  logic [2:0] HBURSTM,
    output logic       next_hold
);

    logic [3:0] remain;
    logic [3:0] remain_nxt;

    always_comb begin
        remain_nxt = remain;
        if (!HSELM) begin
            remain_nxt = 4'd0;
        end else begin
            unique case (htrans_e'(HTRANSM))
                HT_IDLE:   remain_nxt = 4'd0;
                HT_BUSY:   remain_nxt = remain;
                HT_NONSEQ: remain_nxt = burst_remain(hburst_e'(HBURSTM));
                HT_SEQ:    remain_nxt = (remain == 4'd0) ? 4'd0
                                                         : remain - 4'd1;
            endcase
        end
    end

    assign next_hold = (remain_nxt != 4'd0);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            remain <= 4'd0;
        end else if (HREADYM) begin
            remain <= remain_nxt;
        end
    end

endmodule

// File: rtl/ahb_mtx_qos_arbiter.sv
// Four-port AHB matrix arbiter: static priority with age promotion,
// round-robin tie break, burst and lock hold.
module ahb_mtx_qos_arbiter
    import ahb_mtx_pkg::*;
#(
    parameter int AGE_LIMIT = AGE_LIMIT_DEF
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic [3:0] req_port,
    input  logic [7:0] prio_cfg,
    input  logic       HREADYM,
    input  logic       HSELM,
    input  logic [1:0] HTRANSM,
    input  logic [2:0] HBURSTM,
    input  logic       HMASTLOCKM,
    output logic [1:0] addr_in_port,
    output logic       no_port,
    output logic [3:0] starve_flag
);

    logic [3:0] age_q   [4];
    logic [3:0] age_nxt [4];
    logic [2:0] eff     [4];
    logic [3:0] starve_nxt;
    logic       next_hold;
    logic       freeze;
    logic [1:0] start;
    logic [1:0] win;
    logic       found;
    logic [1:0] addr_nxt;
    logic       no_port_nxt;

    ahb_mtx_burst_tracker u_burst (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HREADYM   (HREADYM),
        .HSELM     (HSELM),
        .HTRANSM   (HTRANSM),
        .HBURSTM   (HBURSTM),
        .next_hold (next_hold)
    );

    assign freeze = HMASTLOCKM | next_hold;

    // Urgent ports outrank every static level (0..3).
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            eff[i] = (age_q[i] >= 4'(AGE_LIMIT))
                   ? 3'd4 : {1'b0, prio_cfg[2*i +: 2]};
        end
    end

    always_comb begin
        logic [1:0] idx;
        logic [2:0] best;
        start = no_port ? 2'd0 : addr_in_port + 2'd1;
        found = 1'b0;
        win   = start;
        best  = 3'd0;
        idx   = start;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (req_port[idx] && (!found || eff[idx] > best)) begin
                found = 1'b1;
                win   = idx;
                best  = eff[idx];
            end
        end
    end

    always_comb begin
        addr_nxt    = addr_in_port;
        no_port_nxt = no_port;
        if (!freeze) begin
            if (found) begin
                addr_nxt    = win;
                no_port_nxt = 1'b0;
            end else if (no_port || !HSELM) begin
                no_port_nxt = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (!req_port[i] ||
                (!no_port_nxt && addr_nxt == 2'(i))) begin
                age_nxt[i] = 4'd0;
            end else if (age_q[i] != 4'hF) begin
                age_nxt[i] = age_q[i] + 4'd1;
            end else begin
                age_nxt[i] = age_q[i];
            end
            starve_nxt[i] = (age_nxt[i] >= 4'(AGE_LIMIT));
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            addr_in_port <= 2'd0;
            no_port      <= 1'b1;
            starve_flag  <= 4'd0;
            for (int i = 0; i < 4; i++) age_q[i] <= 4'd0;
        end else if (HREADYM) begin
            addr_in_port <= addr_nxt;
            no_port      <= no_port_nxt;
            starve_flag  <= starve_nxt;
            for (int i = 0; i < 4; i++) age_q[i] <= age_nxt[i];
        end
    end

endmodule

// File: tb/tb_ahb_mtx_qos_arbiter.sv
// Directed bench for ahb_mtx_qos_arbiter with hand-computed grants.
module tb_ahb_mtx_qos_arbiter;

    logic       HCLK;
    logic       HRESET;
    logic [3:0] req_port;
    logic [7:0] prio_cfg;
    logic       HREADYM;
    logic       HSELM;
    logic [1:0] HTRANSM;
    logic [2:0] HBURSTM;
    logic       HMASTLOCKM;
    logic [1:0] addr_in_port;
    logic       no_port;
    logic [3:0] starve_flag;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    ahb_mtx_qos_arbiter #(.AGE_LIMIT(8)) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .req_port     (req_port),
        .prio_cfg     (prio_cfg),
        .HREADYM      (HREADYM),
        .HSELM        (HSELM),
        .HTRANSM      (HTRANSM),
        .HBURSTM      (HBURSTM),
        .HMASTLOCKM   (HMASTLOCKM),
        .addr_in_port (addr_in_port),
        .no_port      (no_port),
        .starve_flag  (starve_flag)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic pulse_reset();
        HRESET = 1'b1;
        #1;
        HRESET = 1'b0;
    endtask

    // {no_port, addr_in_port}
    function automatic logic [7:0] gnt();
        return 8'({no_port, addr_in_port});
    endfunction

    initial begin
        logic [1:0] tr [10];
        logic [1:0] rr34 [8];
        HRESET = 1'b1; req_port = 4'h0; prio_cfg = 8'h00;
        HREADYM = 1'b0; HSELM = 1'b0; HTRANSM = 2'b00;
        HBURSTM = 3'b000; HMASTLOCKM = 1'b0;
        #1;
        check("rst_no_port", 8'(no_port), 8'h1);
        check("rst_addr", 8'(addr_in_port), 8'h0);
        check("rst_starve", 8'(starve_flag), 8'h0);
        @(negedge HCLK);
        HRESET = 1'b0;

        // single request, one-cycle grant latency
        req_port = 4'b0100; HREADYM = 1'b1;
        step();
        check("first_grant", gnt(), 8'h2);

        // round robin among equal priorities from port 0
        pulse_reset();
        prio_cfg = 8'hAA; req_port = 4'hF;
        HSELM = 1'b1; HTRANSM = 2'b10; HBURSTM = 3'b000;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("rr_%0d", k), gnt(), 8'(k % 4));
        end

        // INCR8 with two BUSY beats holds port 0 against port 1
        HTRANSM = 2'b00; req_port = 4'b0001; prio_cfg = 8'h0D;
        step();
        check("incr8_start", gnt(), 8'h0);
        tr = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b11,
               2'b11, 2'b01, 2'b11, 2'b11, 2'b11};
        req_port = 4'b0011; HBURSTM = 3'b101;
        for (int k = 0; k < 10; k++) begin
            HTRANSM = tr[k];
            step();
            check($sformatf("incr8_%0d", k), gnt(), (k == 9) ? 8'h1 : 8'h0);
            if (k == 8) check("incr8_starve", 8'(starve_flag), 8'h2);
        end
        check("incr8_starve_clr", 8'(starve_flag), 8'h0);
        HTRANSM = 2'b00;

        // aging promotes low-priority port 3
        pulse_reset();
        prio_cfg = 8'h3F; req_port = 4'hF; HSELM = 1'b0;
        rr34 = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("age_gnt_%0d", k), gnt(), 8'(rr34[k]));
            if (k == 6) check("age_starve7", 8'(starve_flag), 8'h0);
        end
        check("age_starve8", 8'(starve_flag), 8'h8);
        step();
        check("age_promote", gnt(), 8'h3);
        check("age_clear", 8'(starve_flag), 8'h0);

        // lock freezes the grant
        HMASTLOCKM = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            check($sformatf("lock_%0d", k), gnt(), 8'h3);
        end
        check("lock_starve", 8'(starve_flag), 8'h7);
        HMASTLOCKM = 1'b0;
        step();
        check("unlock_gnt", gnt(), 8'h0);
        check("unlock_starve", 8'(starve_flag), 8'h6);

        // wait states freeze everything
        HREADYM = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("wait_gnt_%0d", k), gnt(), 8'h0);
            check($sformatf("wait_stv_%0d", k), 8'(starve_flag), 8'h6);
        end
        HREADYM = 1'b1;
        step();
        check("resume_gnt", gnt(), 8'h1);
        check("resume_starve", 8'(starve_flag), 8'h4);

        // reset in the middle of an INCR16
        pulse_reset();
        prio_cfg = 8'h0C; req_port = 4'b0001;
        HSELM = 1'b1; HTRANSM = 2'b00;
        step();
        check("i16_start", gnt(), 8'h0);
        req_port = 4'b0011; HBURSTM = 3'b111; HTRANSM = 2'b10;
        step();
        HTRANSM = 2'b11;
        for (int k = 0; k < 4; k++) step();
        check("i16_beat5", gnt(), 8'h0);
        HRESET = 1'b1;
        #1;
        check("i16_rst_no_port", 8'(no_port), 8'h1);
        check("i16_rst_addr", 8'(addr_in_port), 8'h0);
        check("i16_rst_starve", 8'(starve_flag), 8'h0);
        HRESET = 1'b0;
        step();
        check("i16_post_rst", gnt(), 8'h1);

        // idle behaviour with no requests
        req_port = 4'h0; HTRANSM = 2'b00;
        step();
        check("idle_hsel_hold", gnt(), 8'h1);
        HSELM = 1'b0;
        step();
        check("idle_release", gnt(), 8'h5);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
